// File: rtl/xbus_arb.sv
// Two-master arbiter for the controller data bus: round-robin with bounded bursts.
// Define BUSARB_PRIO_EN to give master 0 fixed priority instead.
module xbus_arb #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_data_wr,
   output logic              m0_gnt,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_data_rd,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_data_wr,
   output logic              m1_gnt,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_data_rd,
   output logic              data_sel,
   output logic              data_we,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_to_wr,
   input  logic [DATA_W-1:0] data_to_rd
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] burst_cnt, cnt_nxt;
   logic             last, last_nxt;   // 1: master 1 owned the bus most recently

   logic       own_req, oth_req, own_is1, force_out;
   logic [1:0] oth_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         burst_cnt <= '0;
         last      <= 1'b1;
      end else begin
         state     <= state_nxt;
         burst_cnt <= cnt_nxt;
         last      <= last_nxt;
      end
   end

   // Owner-relative view of the requests so both OWN states share one rule set
   always_comb begin
      own_is1   = (state == OWN1);
      own_req   = own_is1 ? m1_req : m0_req;
      oth_req   = own_is1 ? m0_req : m1_req;
      oth_state = own_is1 ? OWN0 : OWN1;
`ifdef BUSARB_PRIO_EN
      force_out = own_is1;
`else
      force_out = (burst_cnt == BURST_LAST);
`endif
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = burst_cnt;
      last_nxt  = last;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
`ifdef BUSARB_PRIO_EN
            if (m0_req)      state_nxt = OWN0;
            else if (m1_req) state_nxt = OWN1;
`else
            if (m0_req && m1_req) state_nxt = last ? OWN0 : OWN1;
            else if (m0_req)      state_nxt = OWN0;
            else if (m1_req)      state_nxt = OWN1;
`endif
         end
         OWN0, OWN1: begin
            if (!own_req) begin
               state_nxt = oth_req ? oth_state : IDLE;
               cnt_nxt   = '0;
               last_nxt  = own_is1;
            end else if (!oth_req) begin
               cnt_nxt = '0;
            end else if (force_out) begin
               state_nxt = oth_state;
               cnt_nxt   = '0;
               last_nxt  = own_is1;
            end else begin
               cnt_nxt = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Grant-steered bus mux; zero-wait, so ack follows req within the cycle
   always_comb begin
      m0_gnt     = (state == OWN0);
      m1_gnt     = (state == OWN1);
      m0_ack     = m0_gnt & m0_req;
      m1_ack     = m1_gnt & m1_req;
      m0_data_rd = m0_gnt ? data_to_rd : '0;
      m1_data_rd = m1_gnt ? data_to_rd : '0;
      data_sel   = 1'b0;
      data_we    = 1'b0;
      data_addr  = '0;
      data_to_wr = '0;
      if (m0_gnt) begin
         data_sel   = m0_req;
         data_we    = m0_we;
         data_addr  = m0_addr;
         data_to_wr = m0_data_wr;
      end else if (m1_gnt) begin
         data_sel   = m1_req;
         data_we    = m1_we;
         data_addr  = m1_addr;
         data_to_wr = m1_data_wr;
      end
   end

endmodule
